mmio_responder: RTL and testbench

- Memory-mapped responder on the core's data-memory port, using the same en/we/addr/wr_data/data signalling as the on-chip sram.
- Decodes a 4-word window at a base address and contains three things:
  - a transmit FIFO that the core pushes words into, drained by an external valid/ready stream;
  - a status register;
  - a free-running timer.
- Sits beside sram0. The top level routes the core's read data from this block when hit is high, otherwise from sram.

---
 rtl/mmio_responder_pkg.sv | 19 +
 rtl/mmio_responder_if.sv | 25 ++
 rtl/mmio_responder_sync_fifo.sv | 53 +++++
 rtl/mmio_responder.sv | 99 +++++++++
 tb/tb_mmio_responder.sv | 200 ++++++++++++++++++++
 5 files changed

// File: rtl/mmio_responder_pkg.sv
// Shared constants for the MMIO responder: register offsets and STATUS/CTRL bit positions.
package mmio_responder_pkg;

   typedef enum logic [1:0] {
      MMIO_OFF_TXDATA = 2'd0,
      MMIO_OFF_STATUS = 2'd1,
      MMIO_OFF_TIMER  = 2'd2,
      MMIO_OFF_CTRL   = 2'd3
   } mmioOff_e;

   localparam int STATUS_EMPTY_BIT = 0;
   localparam int STATUS_FULL_BIT  = 1;
   localparam int STATUS_OVF_BIT   = 2;
   localparam int STATUS_COUNT_LSB = 3;

   localparam int CTRL_CLR_OVF_BIT  = 0;
   localparam int CTRL_TIMER_EN_BIT = 1;

endpackage

// File: rtl/mmio_responder_if.sv
// Data-memory port (en/we/addr/wr_data/data/hit) plus the TX valid/ready stream of the MMIO responder.
interface mmio_responder_if #(
   parameter int addr_width = 8,
   parameter int data_width = 16
);
   logic                  en;
   logic                  we;
   logic [addr_width-1:0] addr;
   logic [data_width-1:0] wr_data;
   logic [data_width-1:0] data;
   logic                  hit;
   logic                  tx_valid;
   logic [data_width-1:0] tx_data;
   logic                  tx_ready;

   modport slave (
      input  en, we, addr, wr_data, tx_ready,
      output data, hit, tx_valid, tx_data
   );

   modport master (
      output en, we, addr, wr_data, tx_ready,
      input  data, hit, tx_valid, tx_data
   );
endinterface

// File: rtl/mmio_responder_sync_fifo.sv
// Synchronous FIFO with show-ahead head output; a push into a full FIFO succeeds only alongside a pop.
module sync_fifo #(
   parameter int width = 16,
   parameter int depth = 8
) (
   input  logic                     clk,
   input  logic                     rstn,
   input  logic                     push,
   input  logic                     pop,
   input  logic [width-1:0]         wdata,
   output logic [width-1:0]         rdata,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(depth):0]   count
);
   localparam int ptrW = $clog2(depth);

   logic [width-1:0] mem [depth];
   logic [ptrW-1:0]  wrPtr;
   logic [ptrW-1:0]  rdPtr;
   logic             doPush;
   logic             doPop;

   assign doPop  = pop & ~empty;
   assign doPush = push & (~full | doPop);

   // NOTE: storage is not reset; pointers and count define validity, and rdata is masked while empty.
   always_ff @(posedge clk) begin
      if (doPush) mem[wrPtr] <= wdata;
   end

   // NOTE: sequential state always uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         wrPtr <= '0;
         rdPtr <= '0;
         count <= '0;
      end else begin
         if (doPush) wrPtr <= wrPtr + 1'b1;
         if (doPop)  rdPtr <= rdPtr + 1'b1;
         case ({doPush, doPop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: ;
         endcase
      end
   end

   assign empty = (count == '0);
   assign full  = (count == ($clog2(depth) + 1)'(depth));
   assign rdata = empty ? '0 : mem[rdPtr];

endmodule

// File: rtl/mmio_responder.sv
// Memory-mapped responder: TX FIFO, STATUS, TIMER and CTRL in a 4-word window at base_addr.
// Define MMIO_TIMER_EN to build the free-running timer and CTRL timer-enable bit.
module mmio_responder
   import mmio_responder_pkg::*;
#(
   parameter int                  addr_width = 8,
   parameter int                  data_width = 16,
   parameter logic [addr_width-1:0] base_addr = 8'hFC,
   parameter int                  fifo_depth = 8
) (
   input logic              clk,
   input logic              rstn,
   mmio_responder_if.slave  bus
);
   localparam int cntW = $clog2(fifo_depth) + 1;

   mmioOff_e              off;
   logic                  writeHit;
   logic                  pushReq;
   logic                  ctrlWrite;
   logic                  pop;
   logic                  fifoFull;
   logic                  fifoEmpty;
   logic [cntW-1:0]       fifoCount;
   logic                  ovf;
   logic [data_width-1:0] timer;
   logic                  timerEn;
   logic [data_width-1:0] rdWord;

   assign bus.hit   = (bus.addr[addr_width-1:2] == base_addr[addr_width-1:2]);
   assign off       = mmioOff_e'(bus.addr[1:0]);
   assign writeHit  = bus.we & bus.hit;
   assign pushReq   = writeHit & (off == MMIO_OFF_TXDATA);
   assign ctrlWrite = writeHit & (off == MMIO_OFF_CTRL);
   assign pop       = bus.tx_valid & bus.tx_ready;

   sync_fifo #(
      .width (data_width),
      .depth (fifo_depth)
   ) txFifo (
      .clk   (clk),
      .rstn  (rstn),
      .push  (pushReq),
      .pop   (pop),
      .wdata (bus.wr_data),
      .rdata (bus.tx_data),
      .full  (fifoFull),
      .empty (fifoEmpty),
      .count (fifoCount)
   );

   assign bus.tx_valid = ~fifoEmpty;

   // A push dropped on a full FIFO latches ovf until software clears it through CTRL.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         ovf <= 1'b0;
      end else if (pushReq & fifoFull & ~pop) begin
         ovf <= 1'b1;
      end else if (ctrlWrite & bus.wr_data[CTRL_CLR_OVF_BIT]) begin
         ovf <= 1'b0;
      end
   end

`ifdef MMIO_TIMER_EN
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         timer   <= '0;
         timerEn <= 1'b0;
      end else begin
         if (writeHit & (off == MMIO_OFF_TIMER)) timer <= bus.wr_data;
         else if (timerEn)                      timer <= timer + 1'b1;
         if (ctrlWrite & bus.wr_data[CTRL_TIMER_EN_BIT]) timerEn <= 1'b1;
      end
   end
`else
   assign timer   = '0;
   assign timerEn = 1'b0;
`endif

   // NOTE: rdWord gets a default before the case so no path leaves it unassigned (no latch).
   always_comb begin
      rdWord = '0;
      case (off)
         MMIO_OFF_STATUS: begin
            rdWord[STATUS_COUNT_LSB +: cntW] = fifoCount;
            rdWord[STATUS_OVF_BIT]           = ovf;
            rdWord[STATUS_FULL_BIT]          = fifoFull;
            rdWord[STATUS_EMPTY_BIT]         = fifoEmpty;
         end
         MMIO_OFF_TIMER: rdWord = timer;
         MMIO_OFF_CTRL:  rdWord[CTRL_TIMER_EN_BIT] = timerEn;
         default: ;
      endcase
   end

   assign bus.data = (bus.en & bus.hit) ? rdWord : '0;

endmodule

// File: tb/tb_mmio_responder.sv
// Directed plus randomized bench for mmio_responder against a queue-based reference model.
module tb_mmio_responder;
   localparam int         AW    = 8;
   localparam int         DW    = 16;
   localparam int         DEPTH = 8;
   localparam logic [7:0] BASE  = 8'hFC;

   logic clk = 1'b0;
   logic rstn;

   mmio_responder_if #(.addr_width(AW), .data_width(DW)) bus ();

   mmio_responder #(
      .addr_width (AW),
      .data_width (DW),
      .base_addr  (BASE),
      .fifo_depth (DEPTH)
   ) dut (
      .clk  (clk),
      .rstn (rstn),
      .bus  (bus)
   );

   always #5 clk = ~clk;

   int          assertCount = 0;
   int          failCount   = 0;
   logic [15:0] fifoQ [$];
   logic        ovfM;
   logic [15:0] timerM;
   logic        timerEnM;
   logic [15:0] dataObs;
   logic [15:0] txDataObs;
   logic        txValidObs;
   logic        hitObs;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      assertCount++;
      assert (obs === exp) else begin
         failCount++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic resetModel();
      fifoQ.delete();
      ovfM     = 1'b0;
      timerM   = '0;
      timerEnM = 1'b0;
   endtask

   function automatic logic [15:0] readModel(input logic [1:0] off);
      int s;
      s = fifoQ.size();
      case (off)
         2'd1: return 16'(s * 8 + (ovfM ? 4 : 0) + (s == DEPTH ? 2 : 0) + (s == 0 ? 1 : 0));
`ifdef MMIO_TIMER_EN
         2'd2: return timerM;
         2'd3: return timerEnM ? 16'h0002 : 16'h0000;
`endif
         default: return 16'h0000;
      endcase
   endfunction

   // One bus cycle: drive after the falling edge, check combinational outputs, then advance the model.
   task automatic step(input logic e, input logic w, input logic [7:0] a,
                       input logic [15:0] d, input logic rdy);
      logic hitE;
      logic popM;
      logic wasFull;
      logic [1:0] off;
      bus.en = e; bus.we = w; bus.addr = a; bus.wr_data = d; bus.tx_ready = rdy;
      #1;
      hitE = ((a >> 2) == (BASE >> 2));
      off  = a[1:0];
      check("hit", bus.hit, hitE);
      check("data", bus.data, (e && hitE) ? readModel(off) : 16'h0000);
      check("tx_valid", bus.tx_valid, fifoQ.size() != 0);
      check("tx_data", bus.tx_data, (fifoQ.size() != 0) ? fifoQ[0] : 16'h0000);
      dataObs = bus.data; txDataObs = bus.tx_data; txValidObs = bus.tx_valid; hitObs = bus.hit;
      @(posedge clk);
      popM    = (fifoQ.size() != 0) && rdy;
      wasFull = (fifoQ.size() == DEPTH);
      if (popM) void'(fifoQ.pop_front());
      if (w && hitE && off == 2'd0) begin
         if (!wasFull || popM) fifoQ.push_back(d);
         else                  ovfM = 1'b1;
      end
`ifdef MMIO_TIMER_EN
      if (w && hitE && off == 2'd2) timerM = d;
      else if (timerEnM)            timerM = timerM + 16'd1;
      if (w && hitE && off == 2'd3 && d[1]) timerEnM = 1'b1;
`endif
      if (w && hitE && off == 2'd3 && d[0]) ovfM = 1'b0;
      @(negedge clk);
   endtask

   initial begin
      logic [7:0]  a;
      logic [15:0] expTimer;
      logic [15:0] expCtrl;
      rstn = 1'b1;
      bus.en = 1'b0; bus.we = 1'b0; bus.addr = '0; bus.wr_data = '0; bus.tx_ready = 1'b0;
`ifdef MMIO_TIMER_EN
      expTimer = 16'h0001; expCtrl = 16'h0002;
`else
      expTimer = 16'h0000; expCtrl = 16'h0000;
`endif

      // Asynchronous reset asserted between clock edges.
      #7 rstn = 1'b0;
      #1;
      check("reset_tx_valid", bus.tx_valid, 1'b0);
      check("reset_tx_data", bus.tx_data, 16'h0000);
      bus.en = 1'b1; bus.addr = 8'hFD;
      #1 check("reset_status", bus.data, 16'h0001);
      bus.en = 1'b0;
      #1 check("data_idle", bus.data, 16'h0000);
      @(negedge clk);
      rstn = 1'b1;
      resetModel();
      step(1, 0, 8'hFD, 16'h0000, 0);
      check("status_after_reset", dataObs, 16'h0001);
      step(1, 0, 8'hFE, 16'h0000, 0);
      check("timer_after_reset", dataObs, 16'h0000);

      // Two pushes held by back-pressure, then drained.
      step(0, 1, 8'hFC, 16'hA5A5, 0);
      step(0, 1, 8'hFC, 16'h1234, 0);
      step(1, 0, 8'hFD, 16'h0000, 0);
      check("status_two", dataObs, 16'h0010);
      check("head_held", txDataObs, 16'hA5A5);
      step(0, 0, 8'h00, 16'h0000, 1);
      check("drain_first", txDataObs, 16'hA5A5);
      step(0, 0, 8'h00, 16'h0000, 1);
      check("drain_second", txDataObs, 16'h1234);
      step(0, 0, 8'h00, 16'h0000, 0);
      check("drained_empty", txValidObs, 1'b0);

      // Overflow on the ninth push, then clear through CTRL.
      for (int i = 0; i < 9; i++) step(0, 1, 8'hFC, 16'h0100 + 16'(i), 0);
      step(1, 0, 8'hFD, 16'h0000, 0);
      check("status_ovf", dataObs, 16'h0046);
      step(0, 1, 8'hFF, 16'h0001, 0);
      step(1, 0, 8'hFD, 16'h0000, 0);
      check("status_ovf_cleared", dataObs, 16'h0042);

      // Push while full with a simultaneous pop.
      step(0, 1, 8'hFC, 16'h00FF, 1);
      step(1, 0, 8'hFD, 16'h0000, 0);
      check("status_full_pushpop", dataObs, 16'h0042);
      for (int i = 0; i < DEPTH; i++) step(0, 0, 8'h00, 16'h0000, 1);
      check("last_drained", txDataObs, 16'h00FF);
      step(1, 0, 8'hFD, 16'h0000, 0);
      check("status_empty_again", dataObs, 16'h0001);

      // Timer enable, load near the top and observe the wrap.
      step(0, 1, 8'hFF, 16'h0002, 0);
      step(0, 1, 8'hFE, 16'hFFFE, 0);
      repeat (3) step(0, 0, 8'h00, 16'h0000, 0);
      step(1, 0, 8'hFE, 16'h0000, 0);
      check("timer_wrap", dataObs, expTimer);
      step(1, 0, 8'hFF, 16'h0000, 0);
      check("ctrl_read", dataObs, expCtrl);

      // Read and write to TIMER in the same cycle returns the pre-edge value.
      step(1, 1, 8'hFE, 16'h1111, 0);
      step(1, 0, 8'hFE, 16'h0000, 0);
      check("timer_loaded", dataObs, expTimer == 16'h0000 ? 16'h0000 : 16'h1111);

      // Access outside the window is ignored.
      step(1, 1, 8'h10, 16'hBEEF, 0);
      check("miss_hit", hitObs, 1'b0);
      check("miss_data", dataObs, 16'h0000);
      step(1, 0, 8'hFD, 16'h0000, 0);
      check("miss_status", dataObs, 16'h0001);

      // Reset in the middle of a stream.
      step(0, 1, 8'hFC, 16'h0AAA, 0);
      step(0, 1, 8'hFC, 16'h0BBB, 0);
      #2 rstn = 1'b0;
      #1 check("midstream_reset_valid", bus.tx_valid, 1'b0);
      resetModel();
      @(negedge clk);
      rstn = 1'b1;
      step(1, 0, 8'hFD, 16'h0000, 0);
      check("status_after_midreset", dataObs, 16'h0001);

      // Randomized traffic checked cycle by cycle against the model.
      for (int i = 0; i < 600; i++) begin
         if ($urandom_range(0, 9) < 8) a = {6'h3F, 2'($urandom_range(0, 3))};
         else                          a = 8'($urandom);
         step(1'($urandom_range(0, 1)), ($urandom_range(0, 2) == 0), a,
              16'($urandom), ($urandom_range(0, 3) == 0));
      end

      $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
      $finish;
   end
endmodule
